led_fb_write_arbiter: RTL

- Arbitrates the single port of the LED panel framebuffer RAM between two requesters:
  - CPU pixel writes, built from the 24-bit RGB write-data PIO, an address PIO and a toggle-strobe PIO.
  - Reads from the panel scan engine.
- CPU writes are buffered in a small FIFO. Scan reads have priority, and a starvation guard forces writes through.
- Sits between the CPU PIO bank and the framebuffer RAM, in the clk domain.

---
 rtl/led_fb_write_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/led_fb_write_arbiter.sv
// Single-port framebuffer RAM arbiter: scan-engine reads have priority over
// buffered CPU pixel writes, with a starvation guard that forces a write through.
module led_fb_write_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_strobe,
  output logic              wr_full,
  output logic              wr_ack,
  output logic              wr_overflow,
  input  logic              ovf_clear,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ACT_IDLE, ACT_READ, ACT_WRITE, ACT_FORCE} act_e;

  logic              strobe_q;
  logic              armed;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve_cnt;
  logic              vld_p0;
  logic              vld_p1;

  logic              req;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;
  act_e              act;

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v == SC_W'(STARVE_LIMIT)) ? v : v + SC_W'(1);
  endfunction

  assign req        = armed && (wr_strobe != strobe_q);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  always_comb begin
    act = ACT_IDLE;
    if (!fifo_empty && starve_cnt == SC_W'(STARVE_LIMIT)) act = ACT_FORCE;
    else if (rd_req)                                      act = ACT_READ;
    else if (!fifo_empty)                                 act = ACT_WRITE;
  end

  assign pop  = (act == ACT_FORCE) || (act == ACT_WRITE);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = req && (!fifo_full || pop);
  assign drop = req && fifo_full && !pop;

  // Outputs are forced low while reset is held, including the grant.
  assign rd_gnt      = reset_n && (act != ACT_FORCE);
  assign wr_full     = fifo_full;
  assign rd_valid    = vld_p1;
  assign rd_data     = vld_p1 ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q    <= 1'b0;
      armed       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      wr_overflow <= 1'b0;
      wr_ack      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      strobe_q <= wr_strobe;
      armed    <= 1'b1;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      if (drop)           wr_overflow <= 1'b1;
      else if (ovf_clear) wr_overflow <= 1'b0;

      case (act)
        ACT_FORCE, ACT_WRITE: begin
          ram_addr   <= fifo_addr[rd_ptr];
          ram_wdata  <= fifo_data[rd_ptr];
          ram_we     <= 1'b1;
          starve_cnt <= '0;
        end
        ACT_READ: begin
          ram_addr   <= rd_addr;
          ram_we     <= 1'b0;
          starve_cnt <= fifo_empty ? '0 : sat_inc(starve_cnt);
        end
        default: begin
          ram_we     <= 1'b0;
          starve_cnt <= '0;
        end
      endcase

      wr_ack <= wr_ack ^ ram_we;

      // p0: address registered toward RAM; p1: RAM data returned
      vld_p0 <= (act == ACT_READ);
      vld_p1 <= vld_p0;
    end
  end

endmodule
